// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - register-access SPI master: one request becomes one {rw,addr,data} frame
// Optional feature macro SPI_CS_GAP_EN: GAP state holds cs_n high CS_GAP cycles after each frame.
module spi_reg_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              busy
);
  localparam int N  = 1 + ADDR_W + DATA_W;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(N + 1);

  if (CLK_DIV < 2 || CS_GAP < 1) begin : g_param_check
    $error("spi_reg_master: CLK_DIV must be >= 2 and CS_GAP >= 1");
  end

`ifdef SPI_CS_GAP_EN
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam int GW = $clog2(CS_GAP + 1);
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
`endif

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [N-1:0]      tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              mode_q;
  logic              div_last;
  logic              bit_last;

  assign div_last = (div_cnt == DW'(CLK_DIV - 1));
  assign bit_last = (bit_cnt == BW'(N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      mode_q    <= 1'b0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
`ifdef SPI_CS_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            // Read frames carry zeros in the data field.
            tx_sr     <= {req_write, req_addr, req_write ? req_wdata : {DATA_W{1'b0}}};
            mode_q    <= req_mode;
            mosi      <= req_mode ? 1'b0 : req_write;
            cs_n      <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          div_cnt <= div_cnt + DW'(1);
          if (div_last) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          div_cnt <= div_cnt + DW'(1);
          if (div_last) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (mode_q) begin
                mosi  <= tx_sr[N-1];
                tx_sr <= {tx_sr[N-2:0], 1'b0};
              end else begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
              end
            end else begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + BW'(1);
              if (mode_q) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
              end else if (!bit_last) begin
                // Mode 0 keeps the current bit in tx_sr[N-1]; the last bit stays on mosi through HOLD.
                mosi  <= tx_sr[N-2];
                tx_sr <= {tx_sr[N-2:0], 1'b0};
              end
              if (bit_last) state <= HOLD;
            end
          end
        end
        HOLD: begin
          div_cnt <= div_cnt + DW'(1);
          if (div_last) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_sr;
`ifdef SPI_CS_GAP_EN
            gap_cnt   <= '0;
            state     <= GAP;
`else
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
`endif
          end
        end
`ifdef SPI_CS_GAP_EN
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GW'(CS_GAP - 1)) begin
            gap_cnt   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
